// File: rtl/multicycle_controller.sv
// ============================================================================
// multicycle_controller -- FETCH/DECODE/EXEC/MEM/WB sequencer for RV32I core
// Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_controller #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       Opcode,
    input  logic             run,
    input  logic             imem_ready,
    input  logic             dmem_ready,
    output logic             imem_req,
    output logic             dmem_req,
    output logic             IRWrite,
    output logic             PCWrite,
    output logic             ALUSrc,
    output logic             MemtoReg,
    output logic             RegWrite,
    output logic             MemRead,
    output logic             MemWrite,
    output logic [1:0]       ALUOp,
    output logic             Branch,
    output logic             illegal,
    output logic             instr_done,
    output logic [CNT_W-1:0] retired
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;

    localparam logic [6:0] OP_R  = 7'b0110011;
    localparam logic [6:0] OP_I  = 7'b0010011;
    localparam logic [6:0] OP_LW = 7'b0000011;
    localparam logic [6:0] OP_SW = 7'b0100011;
    localparam logic [6:0] OP_BR = 7'b1100011;

    logic [2:0]       state_q, state_d;
    logic [6:0]       op_q;
    logic [CNT_W-1:0] retired_q;

    logic       w_legal;
    logic       w_lw, w_sw, w_br;
    logic       w_alusrc;
    logic [1:0] w_aluop;

    assign w_legal = (Opcode == OP_R) || (Opcode == OP_I) || (Opcode == OP_LW)
                  || (Opcode == OP_SW) || (Opcode == OP_BR);

    // EXEC, MEM and WB all decode from the opcode captured on entry to EXEC
    assign w_lw     = (op_q == OP_LW);
    assign w_sw     = (op_q == OP_SW);
    assign w_br     = (op_q == OP_BR);
    assign w_alusrc = w_lw || w_sw || (op_q == OP_I);
    assign w_aluop  = w_br            ? 2'b01 :
                      (op_q == OP_R)  ? 2'b10 :
                      (op_q == OP_I)  ? 2'b11 : 2'b00;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            op_q      <= '0;
            retired_q <= '0;
        end else begin
            if (state_q == S_DECODE && w_legal) begin
                op_q <= Opcode;
            end
            if (instr_done) begin
                retired_q <= retired_q + CNT_W'(1);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:  if (run && imem_ready) state_d = S_DECODE;
            S_DECODE: state_d = w_legal ? S_EXEC : S_FETCH;
            S_EXEC: begin
                if (w_br)              state_d = S_FETCH;
                else if (w_lw || w_sw) state_d = S_MEM;
                else                   state_d = S_WB;
            end
            S_MEM:    if (dmem_ready) state_d = w_sw ? S_FETCH : S_WB;
            S_WB:     state_d = S_FETCH;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        IRWrite    = 1'b0;
        PCWrite    = 1'b0;
        ALUSrc     = 1'b0;
        MemtoReg   = 1'b0;
        RegWrite   = 1'b0;
        MemRead    = 1'b0;
        MemWrite   = 1'b0;
        ALUOp      = 2'b00;
        Branch     = 1'b0;
        illegal    = 1'b0;
        instr_done = 1'b0;
        case (state_q)
            S_FETCH: begin
                imem_req = run;
                IRWrite  = run && imem_ready;
                PCWrite  = run && imem_ready;
            end
            S_DECODE: illegal = !w_legal;
            S_EXEC: begin
                ALUSrc     = w_alusrc;
                ALUOp      = w_aluop;
                Branch     = w_br;
                instr_done = w_br;
            end
            S_MEM: begin
                ALUSrc     = w_alusrc;
                ALUOp      = w_aluop;
                dmem_req   = 1'b1;
                MemRead    = w_lw;
                MemWrite   = w_sw;
                instr_done = w_sw && dmem_ready;
            end
            S_WB: begin
                ALUSrc     = w_alusrc;
                ALUOp      = w_aluop;
                RegWrite   = 1'b1;
                MemtoReg   = w_lw;
                instr_done = 1'b1;
            end
            default: ;
        endcase
        // Reset must silence the datapath immediately, whatever state we are in
        if (!reset) begin
            imem_req   = 1'b0;
            dmem_req   = 1'b0;
            IRWrite    = 1'b0;
            PCWrite    = 1'b0;
            ALUSrc     = 1'b0;
            MemtoReg   = 1'b0;
            RegWrite   = 1'b0;
            MemRead    = 1'b0;
            MemWrite   = 1'b0;
            ALUOp      = 2'b00;
            Branch     = 1'b0;
            illegal    = 1'b0;
            instr_done = 1'b0;
        end
    end

    assign retired = retired_q;

endmodule

`default_nettype wire

// File: tb/tb_multicycle_controller.sv
// ============================================================================
// tb_multicycle_controller -- directed scoreboard bench for multicycle_controller
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multicycle_controller;

    localparam int CW = 4;

    localparam logic [13:0] E_IREQ = 14'h2000;
    localparam logic [13:0] E_DREQ = 14'h1000;
    localparam logic [13:0] E_IRW  = 14'h0800;
    localparam logic [13:0] E_PCW  = 14'h0400;
    localparam logic [13:0] E_ASRC = 14'h0200;
    localparam logic [13:0] E_M2R  = 14'h0100;
    localparam logic [13:0] E_RW   = 14'h0080;
    localparam logic [13:0] E_MR   = 14'h0040;
    localparam logic [13:0] E_MW   = 14'h0020;
    localparam logic [13:0] E_BR   = 14'h0004;
    localparam logic [13:0] E_ILL  = 14'h0002;
    localparam logic [13:0] E_DONE = 14'h0001;

    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_BAD = 7'b1111111;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic [6:0]    Opcode = '0;
    logic          run = 1'b0;
    logic          imem_ready = 1'b0;
    logic          dmem_ready = 1'b0;
    logic          imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg;
    logic          RegWrite, MemRead, MemWrite, Branch, illegal, instr_done;
    logic [1:0]    ALUOp;
    logic [CW-1:0] retired;

    multicycle_controller #(.CNT_W(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .Opcode     (Opcode),
        .run        (run),
        .imem_ready (imem_ready),
        .dmem_ready (dmem_ready),
        .imem_req   (imem_req),
        .dmem_req   (dmem_req),
        .IRWrite    (IRWrite),
        .PCWrite    (PCWrite),
        .ALUSrc     (ALUSrc),
        .MemtoReg   (MemtoReg),
        .RegWrite   (RegWrite),
        .MemRead    (MemRead),
        .MemWrite   (MemWrite),
        .ALUOp      (ALUOp),
        .Branch     (Branch),
        .illegal    (illegal),
        .instr_done (instr_done),
        .retired    (retired)
    );

    always #5 clk = ~clk;

    logic [13:0] obs;
    assign obs = {imem_req, dmem_req, IRWrite, PCWrite, ALUSrc, MemtoReg, RegWrite,
                  MemRead, MemWrite, ALUOp, Branch, illegal, instr_done};

    typedef struct {
        logic          rst;
        logic          rn;
        logic          ir;
        logic          dr;
        logic [6:0]    op;
        logic [13:0]   exp;
        logic [CW-1:0] ret;
        bit            chk_ret;
    } step_t;

    step_t         q[$];
    int            checks = 0;
    int            errors = 0;
    logic [CW-1:0] exp_ret = '0;

    task automatic push(input logic rst, input logic rn, input logic ir, input logic dr,
                        input logic [6:0] op, input logic [13:0] exp, input bit chk);
        step_t s;
        s.rst = rst; s.rn = rn; s.ir = ir; s.dr = dr; s.op = op;
        s.exp = exp; s.ret = exp_ret; s.chk_ret = chk;
        q.push_back(s);
    endtask

    // Expected per-cycle behaviour of one instruction; the opcode input is
    // scrambled after DECODE so only the captured copy can steer later states.
    task automatic push_instr(input logic [6:0] op, input int iw, input int dw, input logic rm);
        logic        lw, sw, br, ri, ii, legal;
        logic [1:0]  aop;
        logic [13:0] alu, mem;
        lw = (op == OP_LW); sw = (op == OP_SW); br = (op == OP_BR);
        ri = (op == OP_R);  ii = (op == OP_I);
        legal = lw | sw | br | ri | ii;
        aop = br ? 2'b01 : ri ? 2'b10 : ii ? 2'b11 : 2'b00;
        alu = ((lw | sw | ii) ? E_ASRC : 14'h0) | {9'b0, aop, 3'b0};
        for (int i = 0; i < iw; i++) push(1'b1, 1'b1, 1'b0, 1'b1, op, E_IREQ, 1'b1);
        push(1'b1, 1'b1, 1'b1, 1'b1, op, E_IREQ | E_IRW | E_PCW, 1'b1);
        push(1'b1, rm, 1'b1, 1'b1, op, legal ? 14'h0 : E_ILL, 1'b1);
        if (!legal) return;
        push(1'b1, rm, 1'b1, 1'b1, OP_BAD, alu | (br ? (E_BR | E_DONE) : 14'h0), 1'b1);
        if (br) begin
            exp_ret++;
            return;
        end
        if (lw | sw) begin
            mem = E_DREQ | alu | (lw ? E_MR : E_MW);
            for (int i = 0; i < dw; i++) push(1'b1, rm, 1'b1, 1'b0, OP_BAD, mem, 1'b1);
            push(1'b1, rm, 1'b1, 1'b1, OP_BAD, mem | (sw ? E_DONE : 14'h0), 1'b1);
            if (sw) begin
                exp_ret++;
                return;
            end
        end
        push(1'b1, rm, 1'b1, 1'b1, OP_BAD, alu | E_RW | (lw ? E_M2R : 14'h0) | E_DONE, 1'b1);
        exp_ret++;
    endtask

    task automatic drain(input string tag);
        step_t s;
        int    cyc;
        cyc = 0;
        while (q.size() > 0) begin
            s = q.pop_front();
            cyc++;
            reset = s.rst; run = s.rn; imem_ready = s.ir; dmem_ready = s.dr; Opcode = s.op;
            @(negedge clk);
            checks++;
            assert (obs === s.exp) else begin
                errors++;
                $error("FAIL %s cycle %0d outputs: observed %b expected %b", tag, cyc, obs, s.exp);
            end
            if (s.chk_ret) begin
                checks++;
                assert (retired === s.ret) else begin
                    errors++;
                    $error("FAIL %s cycle %0d retired: observed %0d expected %0d", tag, cyc, retired, s.ret);
                end
            end
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        @(posedge clk);
        #1;

        push(1'b0, 1'b1, 1'b1, 1'b1, OP_R, 14'h0, 1'b0);
        exp_ret = '0;
        push(1'b0, 1'b1, 1'b1, 1'b1, OP_R, 14'h0, 1'b1);
        push(1'b0, 1'b1, 1'b1, 1'b1, OP_R, 14'h0, 1'b1);
        drain("reset");

        push_instr(OP_R, 0, 0, 1'b1);
        drain("rtype");
        push_instr(OP_LW, 0, 2, 1'b1);
        drain("lw_wait");
        push_instr(OP_SW, 0, 0, 1'b1);
        push_instr(OP_BR, 0, 0, 1'b1);
        drain("sw_br");
        push_instr(OP_BAD, 0, 0, 1'b1);
        drain("illegal");
        push_instr(OP_I, 2, 0, 1'b0);
        drain("ialu_iwait_runlow");

        push(1'b1, 1'b0, 1'b1, 1'b1, OP_R, 14'h0, 1'b1);
        push(1'b1, 1'b0, 1'b1, 1'b1, OP_R, 14'h0, 1'b1);
        drain("idle");

        push(1'b1, 1'b1, 1'b1, 1'b1, OP_LW, E_IREQ | E_IRW | E_PCW, 1'b1);
        push(1'b1, 1'b1, 1'b1, 1'b1, OP_LW, 14'h0, 1'b1);
        push(1'b1, 1'b1, 1'b1, 1'b1, OP_BAD, E_ASRC, 1'b1);
        push(1'b1, 1'b1, 1'b1, 1'b0, OP_BAD, E_DREQ | E_ASRC | E_MR, 1'b1);
        push(1'b0, 1'b1, 1'b1, 1'b0, OP_BAD, 14'h0, 1'b1);
        exp_ret = '0;
        drain("lw_abort");

        for (int i = 0; i < 16; i++) push_instr(OP_BR, 0, 0, 1'b1);
        drain("wrap");
        checks++;
        assert (retired === 4'd0) else begin
            errors++;
            $error("FAIL wrap_final retired: observed %0d expected 0", retired);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
